// File: rtl/xgmac_stats_pkg.sv
// Shared definitions for the 10G MAC statistics engine: vector bit positions,
// frame-length field placement, counter indices and the decoded-event struct.
package xgmac_stats_pkg;

  localparam int RX_VEC_W = 30;
  localparam int TX_VEC_W = 26;
  localparam int LEN_W    = 14;

  // rx statistics vector fields
  localparam int RX_GOOD_BIT  = 0;
  localparam int RX_BAD_BIT   = 1;
  localparam int RX_FCS_BIT   = 2;
  localparam int RX_BCAST_BIT = 3;
  localparam int RX_MCAST_BIT = 4;
  localparam int RX_LEN_LSB   = 15;

  // tx statistics vector fields (bit 2 carries nothing we count)
  localparam int TX_GOOD_BIT  = 0;
  localparam int TX_BAD_BIT   = 1;
  localparam int TX_RSVD_BIT  = 2;
  localparam int TX_BCAST_BIT = 3;
  localparam int TX_MCAST_BIT = 4;
  localparam int TX_LEN_LSB   = 5;

  // Counter indices double as the host read address map
  localparam int CNT_RX_GOOD       = 0;
  localparam int CNT_RX_BAD        = 1;
  localparam int CNT_RX_FCS        = 2;
  localparam int CNT_RX_BCAST      = 3;
  localparam int CNT_RX_MCAST      = 4;
  localparam int CNT_RX_GOOD_BYTES = 5;
  localparam int CNT_TX_GOOD       = 6;
  localparam int CNT_TX_BAD        = 7;
  localparam int CNT_TX_BCAST      = 8;
  localparam int CNT_TX_MCAST      = 9;
  localparam int CNT_TX_GOOD_BYTES = 10;
  localparam int NUM_CNT           = 11;
  localparam int CNT_IDX_W         = 4;

  // One decoded statistics event; fcs is always 0 on the tx side
  typedef struct packed {
    logic             good;
    logic             bad;
    logic             fcs;
    logic             bcast;
    logic             mcast;
    logic [LEN_W-1:0] len;
  } stat_evt_t;

endpackage

// File: rtl/xgmac_stat_cnt.sv
// Single statistics counter. A clear that coincides with an increment loads
// the increment so that event is not lost; otherwise the counter either
// sticks at all-ones (SATURATE=1) or wraps modulo 2^W (SATURATE=0).
module xgmac_stat_cnt #(
  parameter int W        = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic         clk156,
  input  logic         rst_n,
  input  logic         inc_en,
  input  logic [W-1:0] inc_val,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_d, cnt_q;
  logic [W:0]   sum;

  // Next-count: clear/load, saturating or wrapping add, else hold
  // NOTE: cnt_d gets its hold value first so every path assigns it and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    sum   = {1'b0, cnt_q} + {1'b0, inc_val};
    if (clr) begin
      cnt_d = inc_en ? inc_val : '0;
    end else if (inc_en) begin
      if (SATURATE && sum[W]) begin
        cnt_d = '1;
      end else begin
        cnt_d = sum[W-1:0];
      end
    end
  end

  // Counter register
  // NOTE: state flops use non-blocking assignment so all flops sample pre-edge values.
  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/xgmac_stats.sv
// Statistics engine for the 10G MAC (clk156 domain). Stage 1 registers the
// decoded rx/tx statistics strobes, stage 2 updates eleven counters, and a
// registered read port serves the host register bank.
// Optional build macro XGMAC_STATS_CLR_ON_READ_EN: a read of a valid address
// returns the counter value and clears that counter in the same cycle.
module xgmac_stats
  import xgmac_stats_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int BYTE_CNT_W = 48,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                 clk156,
  input  logic                 rst_n,
  input  logic                 rx_statistics_valid,
  input  logic [RX_VEC_W-1:0]  rx_statistics_vector,
  input  logic                 tx_statistics_valid,
  input  logic [TX_VEC_W-1:0]  tx_statistics_vector,
  input  logic                 stats_clr,
  input  logic                 rd_en,
  input  logic [CNT_IDX_W-1:0] rd_addr,
  output logic [63:0]          rd_data,
  output logic                 rd_valid
);

  stat_evt_t rx_evt_d, rx_evt_q, tx_evt_d, tx_evt_q;
  logic      rx_vld_d, rx_vld_q, tx_vld_d, tx_vld_q;

  logic [NUM_CNT-1:0] inc_en;
  logic [NUM_CNT-1:0] clr_vec;
  logic [63:0]        cnt_ext [NUM_CNT];
  logic [63:0]        rd_mux;
  logic [63:0]        rd_data_d, rd_data_q;
  logic               rd_valid_d, rd_valid_q;

  // Vector bits that carry nothing counted here
  logic unused_vec_bits;
  assign unused_vec_bits = ^{rx_statistics_vector[RX_LEN_LSB-1:RX_MCAST_BIT+1],
                             rx_statistics_vector[RX_VEC_W-1:RX_LEN_LSB+LEN_W],
                             tx_statistics_vector[TX_RSVD_BIT],
                             tx_statistics_vector[TX_VEC_W-1:TX_LEN_LSB+LEN_W],
                             tx_evt_q.fcs};

  // Stage-1 input: decode the vectors so only the counted fields are stored
  always_comb begin
    rx_vld_d       = rx_statistics_valid;
    rx_evt_d.good  = rx_statistics_vector[RX_GOOD_BIT];
    rx_evt_d.bad   = rx_statistics_vector[RX_BAD_BIT];
    rx_evt_d.fcs   = rx_statistics_vector[RX_FCS_BIT];
    rx_evt_d.bcast = rx_statistics_vector[RX_BCAST_BIT];
    rx_evt_d.mcast = rx_statistics_vector[RX_MCAST_BIT];
    rx_evt_d.len   = rx_statistics_vector[RX_LEN_LSB +: LEN_W];

    tx_vld_d       = tx_statistics_valid;
    tx_evt_d.good  = tx_statistics_vector[TX_GOOD_BIT];
    tx_evt_d.bad   = tx_statistics_vector[TX_BAD_BIT];
    tx_evt_d.fcs   = 1'b0;
    tx_evt_d.bcast = tx_statistics_vector[TX_BCAST_BIT];
    tx_evt_d.mcast = tx_statistics_vector[TX_MCAST_BIT];
    tx_evt_d.len   = tx_statistics_vector[TX_LEN_LSB +: LEN_W];
  end

  // Stage-1 register; reset flushes any pending event
  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) begin
      rx_vld_q <= 1'b0;
      rx_evt_q <= '0;
      tx_vld_q <= 1'b0;
      tx_evt_q <= '0;
    end else begin
      rx_vld_q <= rx_vld_d;
      rx_evt_q <= rx_evt_d;
      tx_vld_q <= tx_vld_d;
      tx_evt_q <= tx_evt_d;
    end
  end

  // Stage-2 increment enables; byte counters only count good frames
  always_comb begin
    inc_en                    = '0;
    inc_en[CNT_RX_GOOD]       = rx_vld_q & rx_evt_q.good;
    inc_en[CNT_RX_BAD]        = rx_vld_q & rx_evt_q.bad;
    inc_en[CNT_RX_FCS]        = rx_vld_q & rx_evt_q.fcs;
    inc_en[CNT_RX_BCAST]      = rx_vld_q & rx_evt_q.bcast;
    inc_en[CNT_RX_MCAST]      = rx_vld_q & rx_evt_q.mcast;
    inc_en[CNT_RX_GOOD_BYTES] = rx_vld_q & rx_evt_q.good;
    inc_en[CNT_TX_GOOD]       = tx_vld_q & tx_evt_q.good;
    inc_en[CNT_TX_BAD]        = tx_vld_q & tx_evt_q.bad;
    inc_en[CNT_TX_BCAST]      = tx_vld_q & tx_evt_q.bcast;
    inc_en[CNT_TX_MCAST]      = tx_vld_q & tx_evt_q.mcast;
    inc_en[CNT_TX_GOOD_BYTES] = tx_vld_q & tx_evt_q.good;
  end

  // Per-counter clear: global clear, plus the addressed counter on a read when enabled
  always_comb begin
    clr_vec = {NUM_CNT{stats_clr}};
`ifdef XGMAC_STATS_CLR_ON_READ_EN
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_en && (rd_addr == CNT_IDX_W'(i))) begin
        clr_vec[i] = 1'b1;
      end
    end
`endif
  end

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    localparam bit IS_BYTES = (i == CNT_RX_GOOD_BYTES) || (i == CNT_TX_GOOD_BYTES);
    localparam int W        = IS_BYTES ? BYTE_CNT_W : CNT_W;

    logic [W-1:0] inc_val;
    logic [W-1:0] cnt;

    if (i == CNT_RX_GOOD_BYTES) begin : g_rx_len
      assign inc_val = W'(rx_evt_q.len);
    end else if (i == CNT_TX_GOOD_BYTES) begin : g_tx_len
      assign inc_val = W'(tx_evt_q.len);
    end else begin : g_one
      assign inc_val = W'(1);
    end

    xgmac_stat_cnt #(
      .W        (W),
      .SATURATE (SATURATE)
    ) u_cnt (
      .clk156  (clk156),
      .rst_n   (rst_n),
      .inc_en  (inc_en[i]),
      .inc_val (inc_val),
      .clr     (clr_vec[i]),
      .cnt     (cnt)
    );

    assign cnt_ext[i] = 64'(cnt);
  end

  // Read mux; unmapped addresses return 0
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_addr == CNT_IDX_W'(i)) begin
        rd_mux = cnt_ext[i];
      end
    end
  end

  // Read port next-state: capture on rd_en, otherwise hold data
  always_comb begin
    rd_valid_d = rd_en;
    rd_data_d  = rd_en ? rd_mux : rd_data_q;
  end

  // Read port register
  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_xgmac_stats.sv
// Directed bench for xgmac_stats. A default instance carries most checks; two
// CNT_W=8 instances (saturating and wrapping) share its stimulus for the
// overflow case. Honours XGMAC_STATS_CLR_ON_READ_EN for the clear-on-read case.
module tb_xgmac_stats;

  logic        clk156 = 1'b0;
  logic        rst_n;
  logic        rx_statistics_valid;
  logic [29:0] rx_statistics_vector;
  logic        tx_statistics_valid;
  logic [25:0] tx_statistics_vector;
  logic        stats_clr;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [63:0] rd_data, rd_data_s, rd_data_w;
  logic        rd_valid, rd_valid_s, rd_valid_w;

  int checks = 0;
  int errors = 0;

  always #5 clk156 = ~clk156;

  xgmac_stats dut (
    .clk156               (clk156),
    .rst_n                (rst_n),
    .rx_statistics_valid  (rx_statistics_valid),
    .rx_statistics_vector (rx_statistics_vector),
    .tx_statistics_valid  (tx_statistics_valid),
    .tx_statistics_vector (tx_statistics_vector),
    .stats_clr            (stats_clr),
    .rd_en                (rd_en),
    .rd_addr              (rd_addr),
    .rd_data              (rd_data),
    .rd_valid             (rd_valid)
  );

  xgmac_stats #(.CNT_W(8), .SATURATE(1'b1)) dut_s (
    .clk156               (clk156),
    .rst_n                (rst_n),
    .rx_statistics_valid  (rx_statistics_valid),
    .rx_statistics_vector (rx_statistics_vector),
    .tx_statistics_valid  (tx_statistics_valid),
    .tx_statistics_vector (tx_statistics_vector),
    .stats_clr            (stats_clr),
    .rd_en                (rd_en),
    .rd_addr              (rd_addr),
    .rd_data              (rd_data_s),
    .rd_valid             (rd_valid_s)
  );

  xgmac_stats #(.CNT_W(8), .SATURATE(1'b0)) dut_w (
    .clk156               (clk156),
    .rst_n                (rst_n),
    .rx_statistics_valid  (rx_statistics_valid),
    .rx_statistics_vector (rx_statistics_vector),
    .tx_statistics_valid  (tx_statistics_valid),
    .tx_statistics_vector (tx_statistics_vector),
    .stats_clr            (stats_clr),
    .rd_en                (rd_en),
    .rd_addr              (rd_addr),
    .rd_data              (rd_data_w),
    .rd_valid             (rd_valid_w)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] mk_rx(input bit good, input bit bad, input bit fcs,
                                        input bit bcast, input bit mcast,
                                        input logic [13:0] len);
    logic [29:0] v;
    v        = '0;
    v[0]     = good;
    v[1]     = bad;
    v[2]     = fcs;
    v[3]     = bcast;
    v[4]     = mcast;
    v[28:15] = len;
    return v;
  endfunction

  function automatic logic [25:0] mk_tx(input bit good, input bit bad, input bit bcast,
                                        input bit mcast, input logic [13:0] len);
    logic [25:0] v;
    v       = '0;
    v[0]    = good;
    v[1]    = bad;
    v[3]    = bcast;
    v[4]    = mcast;
    v[18:5] = len;
    return v;
  endfunction

  task automatic rx_event(input logic [29:0] vec);
    @(negedge clk156);
    rx_statistics_valid  = 1'b1;
    rx_statistics_vector = vec;
    @(negedge clk156);
    rx_statistics_valid  = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk156);
    stats_clr = 1'b1;
    @(negedge clk156);
    stats_clr = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [63:0] exp, input string tag);
    @(negedge clk156);
    rd_en   = 1'b1;
    rd_addr = a;
    @(posedge clk156);
    #1;
    check({tag, "_vld"}, {63'd0, rd_valid}, 64'd1);
    check(tag, rd_data, exp);
    rd_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n                = 1'b0;
    rx_statistics_valid  = 1'b0;
    rx_statistics_vector = '0;
    tx_statistics_valid  = 1'b0;
    tx_statistics_vector = '0;
    stats_clr            = 1'b0;
    rd_en                = 1'b0;
    rd_addr              = '0;

    // Power-on reset
    repeat (3) @(negedge clk156);
    check("por_rd_valid", {63'd0, rd_valid}, 64'd0);
    check("por_rd_data", rd_data, 64'd0);
    rst_n = 1'b1;

    // Build state, then reset mid-read with an event pending in stage 1
    rx_event(mk_rx(1, 0, 0, 0, 0, 14'd100));
    rd(4'd5, 64'd100, "pre_rst_bytes");
    @(negedge clk156);
    rd_en                = 1'b1;
    rd_addr              = 4'd5;
    rx_statistics_valid  = 1'b1;
    rx_statistics_vector = mk_rx(1, 0, 0, 0, 0, 14'd100);
    @(posedge clk156);
    #1;
    rx_statistics_valid = 1'b0;
    check("mid_rd_valid", {63'd0, rd_valid}, 64'd1);
    check("mid_rd_data", rd_data, 64'd100);
    rst_n = 1'b0;
    #1;
    check("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    check("rst_rd_data", rd_data, 64'd0);
    @(posedge clk156);
    #1;
    check("rst_hold_rd_valid", {63'd0, rd_valid}, 64'd0);
    @(negedge clk156);
    rd_en = 1'b0;
    rst_n = 1'b1;
    for (int a = 0; a < 11; a++) rd(4'(a), 64'd0, $sformatf("rst_cnt%0d", a));

    // Three good broadcast rx frames of 1514 bytes
    repeat (3) rx_event(mk_rx(1, 0, 0, 1, 0, 14'd1514));
    rd(4'd0, 64'd3, "rx_good_x3");
    rd(4'd3, 64'd3, "rx_bcast_x3");
    rd(4'd5, 64'd4542, "rx_bytes_x3");
    rd(4'd1, 64'd0, "rx_bad_x3");
    rd(4'd4, 64'd0, "rx_mcast_x3");

    // Bad frame with FCS error: byte count unchanged
    rx_event(mk_rx(0, 1, 1, 0, 0, 14'd64));
    rd(4'd1, 64'd1, "rx_bad_fcs");
    rd(4'd2, 64'd1, "rx_fcs");
    rd(4'd5, 64'd4542, "rx_bytes_bad");
    rd(4'd11, 64'd0, "addr11");
    rd(4'd15, 64'd0, "addr15");
    rd(4'd0, 64'd3, "rx_good_bad");

    // Idle cycle: rd_valid drops, rd_data holds
    @(posedge clk156);
    #1;
    check("idle_rd_valid", {63'd0, rd_valid}, 64'd0);
    check("idle_rd_data", rd_data, 64'd3);

    // Simultaneous rx/tx good frames; not visible at N+1, visible at N+2
    pulse_clr();
    @(negedge clk156);
    rx_statistics_valid  = 1'b1;
    rx_statistics_vector = mk_rx(1, 0, 0, 0, 0, 14'd60);
    tx_statistics_valid  = 1'b1;
    tx_statistics_vector = mk_tx(1, 0, 0, 0, 14'd100);
    @(negedge clk156);
    rx_statistics_valid = 1'b0;
    tx_statistics_valid = 1'b0;
    rd_en               = 1'b1;
    rd_addr             = 4'd5;
    @(posedge clk156);
    #1;
    check("rx_bytes_n1", rd_data, 64'd0);
    rd_en = 1'b0;
    rd(4'd5, 64'd60, "rx_bytes_n2");
    rd(4'd10, 64'd100, "tx_bytes_n2");
    rd(4'd0, 64'd1, "rx_good_both");
    rd(4'd6, 64'd1, "tx_good_both");
    rd(4'd8, 64'd0, "tx_bcast_both");

    // stats_clr coincides with a stage-2 tx good frame of 128 bytes
    @(negedge clk156);
    tx_statistics_valid  = 1'b1;
    tx_statistics_vector = mk_tx(1, 0, 0, 0, 14'd128);
    @(negedge clk156);
    tx_statistics_valid = 1'b0;
    stats_clr           = 1'b1;
    @(negedge clk156);
    stats_clr = 1'b0;
    rd(4'd6, 64'd1, "clr_race_tx_good");
    rd(4'd10, 64'd128, "clr_race_tx_bytes");
    rd(4'd5, 64'd0, "clr_race_rx_bytes");
    rd(4'd0, 64'd0, "clr_race_rx_good");

    // 260 back-to-back good rx events of 1 byte
    pulse_clr();
    @(negedge clk156);
    rx_statistics_valid  = 1'b1;
    rx_statistics_vector = mk_rx(1, 0, 0, 0, 0, 14'd1);
    repeat (260) @(negedge clk156);
    rx_statistics_valid = 1'b0;
    @(negedge clk156);
    rd_en   = 1'b1;
    rd_addr = 4'd0;
    @(posedge clk156);
    #1;
    check("ovf_main", rd_data, 64'd260);
    check("ovf_sat", rd_data_s, 64'd255);
    check("ovf_wrap", rd_data_w, 64'd4);
    check("ovf_wrap_vld", {63'd0, rd_valid_w}, 64'd1);
    rd_en = 1'b0;
    @(negedge clk156);
    rd_en   = 1'b1;
    rd_addr = 4'd5;
    @(posedge clk156);
    #1;
    check("ovf_sat_bytes", rd_data_s, 64'd260);
    rd_en = 1'b0;

    // Clear-on-read behaviour
    pulse_clr();
    repeat (5) rx_event(mk_rx(1, 0, 0, 0, 0, 14'd10));
    rd(4'd0, 64'd5, "cor_first");
`ifdef XGMAC_STATS_CLR_ON_READ_EN
    rd(4'd0, 64'd0, "cor_second");
`else
    rd(4'd0, 64'd5, "cor_second");
`endif
    rd(4'd5, 64'd50, "cor_bytes");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
